// File: rtl/arm_data_mem_responder_if.sv
// Load/store request and response channels between the core's data port
// and the data memory responder.
interface arm_data_mem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/arm_data_mem_responder.sv
// Single-ported word RAM answering one load/store at a time, with a fixed
// number of wait states and error flagging for misaligned/out-of-range accesses.
module arm_data_mem_responder #(
   parameter int unsigned DEPTH       = 1024,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   arm_data_mem_responder_if.slave   bus,
   output logic                      busy
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam logic [32:0] LIMIT = 33'(DEPTH) << 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        err_q;

   logic        write_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  be_q;

   logic        accept;
   logic        access;
   logic        use_bus;
   logic        acc_write;
   logic [31:0] acc_addr;
   logic [31:0] acc_wdata;
   logic [3:0]  acc_be;
   logic        acc_err;
   logic [AW-1:0] acc_widx;
   logic [31:0] rdata_w;

   assign bus.req_ready = rst && (state_q == ST_IDLE);
   assign bus.rsp_valid = (state_q == ST_RESP);
   assign bus.rsp_err   = err_q;
   assign bus.rsp_rdata = rdata_w;
   assign busy          = (state_q != ST_IDLE);
   assign accept        = bus.req_valid && bus.req_ready;

   // With no wait states the access happens on the acceptance edge itself,
   // so the live request fields are used instead of the latched copy.
   assign use_bus   = (state_q == ST_IDLE);
   assign acc_write = use_bus ? bus.req_write : write_q;
   assign acc_addr  = use_bus ? bus.req_addr  : addr_q;
   assign acc_wdata = use_bus ? bus.req_wdata : wdata_q;
   assign acc_be    = use_bus ? bus.req_be    : be_q;
   assign acc_err   = (acc_addr[1:0] != 2'b00) || ({1'b0, acc_addr} >= LIMIT);
   assign acc_widx  = acc_addr[AW+1:2];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      access  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (WAIT_CYCLES == 0) begin
                  state_d = ST_RESP;
                  access  = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = 4'(WAIT_CYCLES - 1);
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_RESP;
               access  = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (access) begin
            err_q <= acc_err;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         write_q <= bus.req_write;
         addr_q  <= bus.req_addr;
         wdata_q <= bus.req_wdata;
         be_q    <= bus.req_be;
      end
   end

   // One byte-wide RAM per lane so byte enables map onto independent write ports;
   // a reset on the access edge suppresses the write, discarding the store.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] mem_q [DEPTH];
         logic [7:0] rd_q;

         always_ff @(posedge clk) begin
            if (rst && access && acc_write && !acc_err && acc_be[gi]) begin
               mem_q[acc_widx] <= acc_wdata[8*gi +: 8];
            end
         end

         always_ff @(posedge clk) begin
            if (!rst) begin
               rd_q <= 8'h00;
            end else if (access) begin
               rd_q <= (acc_write || acc_err) ? 8'h00 : mem_q[acc_widx];
            end
         end

         assign rdata_w[8*gi +: 8] = rd_q;
      end
   endgenerate

endmodule

// File: tb/tb_arm_data_mem_responder.sv
// Two responders (wait-state and zero-wait configs) driven by directed and
// random load/store traffic, checked every cycle against a transaction model.
module tb_arm_data_mem_responder;

   localparam int WC0  = 2;
   localparam int WC1  = 0;
   localparam int DEP0 = 1024;
   localparam int DEP1 = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic busy0, busy1;

   arm_data_mem_responder_if bus0();
   arm_data_mem_responder_if bus1();

   arm_data_mem_responder #(.DEPTH(DEP0), .WAIT_CYCLES(WC0)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0), .busy(busy0));
   arm_data_mem_responder #(.DEPTH(DEP1), .WAIT_CYCLES(WC1)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1), .busy(busy1));

   logic        drv_valid [2];
   logic        drv_write [2];
   logic [31:0] drv_addr  [2];
   logic [31:0] drv_wdata [2];
   logic [3:0]  drv_be    [2];
   logic        drv_rsp_ready [2];

   logic        mon_ready [2];
   logic        mon_valid [2];
   logic        mon_err   [2];
   logic        mon_busy  [2];
   logic [31:0] mon_rdata [2];

   assign bus0.req_valid = drv_valid[0];
   assign bus0.req_write = drv_write[0];
   assign bus0.req_addr  = drv_addr[0];
   assign bus0.req_wdata = drv_wdata[0];
   assign bus0.req_be    = drv_be[0];
   assign bus0.rsp_ready = drv_rsp_ready[0];
   assign bus1.req_valid = drv_valid[1];
   assign bus1.req_write = drv_write[1];
   assign bus1.req_addr  = drv_addr[1];
   assign bus1.req_wdata = drv_wdata[1];
   assign bus1.req_be    = drv_be[1];
   assign bus1.rsp_ready = drv_rsp_ready[1];

   assign mon_ready[0] = bus0.req_ready;
   assign mon_valid[0] = bus0.rsp_valid;
   assign mon_err[0]   = bus0.rsp_err;
   assign mon_rdata[0] = bus0.rsp_rdata;
   assign mon_busy[0]  = busy0;
   assign mon_ready[1] = bus1.req_ready;
   assign mon_valid[1] = bus1.rsp_valid;
   assign mon_err[1]   = bus1.rsp_err;
   assign mon_rdata[1] = bus1.rsp_rdata;
   assign mon_busy[1]  = busy1;

   int vectors     = 0;
   int miscompares = 0;
   int wc_t  [2] = '{WC0, WC1};
   int dep_t [2] = '{DEP0, DEP1};

   // Transaction-level model: one outstanding request per DUT, whose response
   // becomes due WAIT_CYCLES+1 cycles after acceptance.
   bit          started = 1'b0;
   int          cyc = 0;
   bit          m_busy  [2];
   int          m_due   [2];
   logic        m_wr    [2];
   logic [31:0] m_addr  [2];
   logic [31:0] m_wd    [2];
   logic [3:0]  m_be    [2];
   logic [31:0] m_rd    [2];
   logic        m_err   [2];
   bit          m_rdchk [2];
   bit          m_zero  [2];
   logic [31:0] mmem   [2][1024];
   logic [3:0]  mknown [2][1024];

   task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] want);
      vectors++;
      if (act !== want) begin
         miscompares++;
         $display("FAIL %s dut%0d: got 0x%08h expected 0x%08h (t=%0t)", name, d, act, want, $time);
      end
   endtask

   task automatic summary_and_stop(input string what, input int d);
      vectors++;
      miscompares++;
      $display("FAIL timeout_%s dut%0d (t=%0t)", what, d, $time);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "bench stopped on timeout");
   endtask

   initial begin : compare_proc
      logic er;
      int   w;
      logic want_ready, want_valid;
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (m_busy[d] && cyc == m_due[d]) begin
               er = (m_addr[d][1:0] != 2'b00) ||
                    (longint'(m_addr[d]) >= longint'(dep_t[d]) * 4);
               m_err[d]   = er;
               m_rd[d]    = 32'h0;
               m_rdchk[d] = 1'b1;
               m_zero[d]  = 1'b0;
               if (!er) begin
                  w = int'(m_addr[d] >> 2);
                  if (m_wr[d]) begin
                     for (int i = 0; i < 4; i++) begin
                        if (m_be[d][i]) begin
                           mmem[d][w][8*i +: 8] = m_wd[d][8*i +: 8];
                           mknown[d][w][i] = 1'b1;
                        end
                     end
                  end else begin
                     m_rd[d]    = mmem[d][w];
                     m_rdchk[d] = (mknown[d][w] == 4'hF);
                  end
               end
            end
            want_ready = rst && !m_busy[d];
            want_valid = m_busy[d] && (cyc >= m_due[d]);
            if (started) begin
               chk("req_ready", d, 32'(mon_ready[d]), 32'(want_ready));
               chk("rsp_valid", d, 32'(mon_valid[d]), 32'(want_valid));
               chk("busy",      d, 32'(mon_busy[d]),  32'(m_busy[d]));
               if (want_valid) begin
                  chk("rsp_err", d, 32'(mon_err[d]), 32'(m_err[d]));
                  if (m_rdchk[d]) chk("rsp_rdata", d, mon_rdata[d], m_rd[d]);
               end else if (m_zero[d]) begin
                  chk("rsp_err_rst",   d, 32'(mon_err[d]), 32'h0);
                  chk("rsp_rdata_rst", d, mon_rdata[d], 32'h0);
               end
            end
            if (!rst) begin
               m_busy[d] = 1'b0;
               m_zero[d] = 1'b1;
            end else if (want_ready && drv_valid[d]) begin
               m_busy[d] = 1'b1;
               m_due[d]  = cyc + wc_t[d] + 1;
               m_wr[d]   = drv_write[d];
               m_addr[d] = drv_addr[d];
               m_wd[d]   = drv_wdata[d];
               m_be[d]   = drv_be[d];
            end else if (want_valid && drv_rsp_ready[d]) begin
               m_busy[d] = 1'b0;
            end
         end
         cyc++;
      end
   end

   // mode 0: normal; 1: reset while the request is waiting; 2: reset while the response is held
   task automatic txn(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, input int hold, input int mode,
                      output logic [31:0] rdata, output logic err, output int lat);
      int n;
      rdata = 32'h0;
      err   = 1'b0;
      lat   = 0;
      @(posedge clk); #1;
      drv_valid[d] = 1'b1;
      drv_write[d] = wr;
      drv_addr[d]  = addr;
      drv_wdata[d] = wd;
      drv_be[d]    = be;
      drv_rsp_ready[d] = 1'b0;
      n = 0;
      @(negedge clk);
      while (!mon_ready[d] && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!mon_ready[d]) summary_and_stop("accept", d);
      @(posedge clk); #1;
      drv_valid[d] = 1'b0;
      drv_write[d] = 1'($urandom);
      drv_addr[d]  = $urandom;
      drv_wdata[d] = $urandom;
      drv_be[d]    = 4'($urandom);
      drv_rsp_ready[d] = (hold == 0 && mode == 0);
      if (mode == 1) begin
         rst = 1'b0;
         @(posedge clk); #1;
         rst = 1'b1;
         @(negedge clk);
         chk("rsp_valid_after_rst", d, 32'(mon_valid[d]), 32'h0);
         chk("busy_after_rst",      d, 32'(mon_busy[d]),  32'h0);
         $display("dut%0d %s addr=0x%08h wdata=0x%08h be=%h discarded by reset", d,
                  wr ? "ST" : "LD", addr, wd, be);
         return;
      end
      do begin
         @(negedge clk);
         lat++;
      end while (!mon_valid[d] && lat < 40);
      if (!mon_valid[d]) summary_and_stop("response", d);
      rdata = mon_rdata[d];
      err   = mon_err[d];
      if (mode == 2) begin
         @(posedge clk); #1;
         rst = 1'b0;
         @(posedge clk); #1;
         rst = 1'b1;
      end else if (hold == 0) begin
         @(posedge clk); #1;
         drv_rsp_ready[d] = 1'b0;
      end else begin
         repeat (hold - 1) begin
            @(negedge clk);
            chk("rdata_stable", d, mon_rdata[d], rdata);
         end
         @(posedge clk); #1;
         drv_rsp_ready[d] = 1'b1;
         @(posedge clk); #1;
         drv_rsp_ready[d] = 1'b0;
      end
      $display("dut%0d %s addr=0x%08h wdata=0x%08h be=%h -> rdata=0x%08h err=%0d lat=%0d hold=%0d mode=%0d",
               d, wr ? "ST" : "LD", addr, wd, be, rdata, err, lat, hold, mode);
   endtask

   initial begin : watchdog
      #2_000_000;
      summary_and_stop("watchdog", 0);
   end

   initial begin : stimulus
      logic [31:0] rd;
      logic        er;
      int          lt;
      logic [31:0] a;
      int          d;

      for (int k = 0; k < 2; k++) begin
         drv_valid[k] = 1'b1;
         drv_write[k] = 1'b0;
         drv_addr[k]  = 32'h0;
         drv_wdata[k] = 32'h0;
         drv_be[k]    = 4'hF;
         drv_rsp_ready[k] = 1'b0;
         m_busy[k] = 1'b0;
         m_zero[k] = 1'b1;
         m_rdchk[k] = 1'b0;
         for (int j = 0; j < 1024; j++) mknown[k][j] = 4'h0;
      end
      rst = 1'b0;

      // reset held for three edges with a request pending
      @(posedge clk); #1;
      started = 1'b1;
      @(negedge clk);
      chk("req_ready_in_rst", 0, 32'(mon_ready[0]), 32'h0);
      chk("busy_in_rst",      0, 32'(mon_busy[0]),  32'h0);
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      drv_valid[0] = 1'b0;
      drv_valid[1] = 1'b0;
      @(negedge clk);
      chk("req_ready_after_rst", 0, 32'(mon_ready[0]), 32'h1);
      chk("req_ready_after_rst", 1, 32'(mon_ready[1]), 32'h1);

      // wait-state config: basic store/load, byte lanes, errors, backpressure
      txn(0, 1, 32'h0, 32'h0000_0005, 4'hF, 0, 0, rd, er, lt);
      chk("st_latency", 0, 32'(lt), 32'd3);
      chk("st_err",     0, 32'(er), 32'h0);
      chk("st_rdata",   0, rd, 32'h0);
      txn(0, 0, 32'h0, 32'h0, 4'h0, 1, 0, rd, er, lt);
      chk("ld0", 0, rd, 32'h0000_0005);
      txn(0, 1, 32'h8, 32'hAABB_CCDD, 4'hF, 0, 0, rd, er, lt);
      txn(0, 1, 32'h8, 32'h1122_3344, 4'b0101, 2, 0, rd, er, lt);
      txn(0, 0, 32'h8, 32'h0, 4'hF, 0, 0, rd, er, lt);
      chk("ld8_lanes", 0, rd, 32'hAA22_CC44);
      txn(0, 1, 32'h2, 32'hFFFF_FFFF, 4'hF, 0, 0, rd, er, lt);
      chk("st_misaligned_err", 0, 32'(er), 32'h1);
      txn(0, 0, 32'h1000, 32'h0, 4'hF, 0, 0, rd, er, lt);
      chk("ld_range_err",   0, 32'(er), 32'h1);
      chk("ld_range_rdata", 0, rd, 32'h0);
      txn(0, 0, 32'h0, 32'h0, 4'hF, 4, 0, rd, er, lt);
      chk("ld0_backpressure", 0, rd, 32'h0000_0005);

      // reset while a store waits, then while a committed store's response is held
      txn(0, 1, 32'h4, 32'h0BAD_F00D, 4'hF, 0, 0, rd, er, lt);
      txn(0, 1, 32'h4, 32'hDEAD_BEEF, 4'hF, 0, 1, rd, er, lt);
      txn(0, 0, 32'h4, 32'h0, 4'hF, 0, 0, rd, er, lt);
      chk("ld4_after_discard", 0, rd, 32'h0BAD_F00D);
      txn(0, 1, 32'hC, 32'h1234_5678, 4'hF, 0, 2, rd, er, lt);
      txn(0, 0, 32'hC, 32'h0, 4'hF, 0, 0, rd, er, lt);
      chk("ldC_after_commit", 0, rd, 32'h1234_5678);
      txn(0, 1, 32'hFFC, 32'hCAFE_F00D, 4'hF, 0, 0, rd, er, lt);
      txn(0, 0, 32'hFFC, 32'h0, 4'hF, 0, 0, rd, er, lt);
      chk("ld_last_word",     0, rd, 32'hCAFE_F00D);
      chk("ld_last_word_err", 0, 32'(er), 32'h0);

      // zero-wait config
      txn(1, 1, 32'h3C, 32'h0000_0077, 4'hF, 0, 0, rd, er, lt);
      chk("nowait_latency", 1, 32'(lt), 32'd1);
      txn(1, 0, 32'h3C, 32'h0, 4'hF, 0, 0, rd, er, lt);
      chk("nowait_ld", 1, rd, 32'h0000_0077);
      txn(1, 0, 32'h40, 32'h0, 4'hF, 0, 0, rd, er, lt);
      chk("nowait_range_err", 1, 32'(er), 32'h1);

      // random traffic on both configs
      for (int i = 0; i < 160; i++) begin
         d = i % 2;
         case ($urandom_range(0, 9))
            0:       a = 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
            1:       a = 32'(dep_t[d] * 4 - 4);
            2:       a = 32'(dep_t[d] * 4 + 4 * $urandom_range(0, 3));
            3:       a = 32'hFFFF_FFFC;
            default: a = 32'(4 * $urandom_range(0, 15));
         endcase
         txn(d, 1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3), 0, rd, er, lt);
         chk("rand_latency", d, 32'(lt), 32'(wc_t[d] + 1));
      end

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
